// File: rtl/frontend_ctrl_pkg.sv
// Shared types and constants for the frontend reset/flush sequencer.
// Holds the sequencer state enum, default parameters and a width helper.
package frontend_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        FLUSH   = 2'd3
    } state_e;

    localparam int DEF_N_STAGES     = 3;
    localparam int DEF_RST_CYCLES   = 4;
    localparam int DEF_STAGE_GAP    = 2;
    localparam int DEF_N_REQ        = 2;
    localparam int DEF_FLUSH_CYCLES = 2;

    // One counter is shared by hold, release-gap and flush timing,
    // so it must hold the largest of the three terminal counts.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/frontend_rst_ctrl_prio_arb.sv
// Fixed-priority arbiter, lowest asserted index wins.
// Ports: req (N requests in), gnt (one-hot grant out, zero when idle).
module prio_arb #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    // Two's-complement trick isolates the lowest set bit.
    always_comb begin
        gnt = req & (~req + 1'b1);
    end

endmodule

// File: rtl/frontend_rst_ctrl.sv
// Reset/flush sequencer for the fetch frontend: timed staged reset release,
// then prioritised flush pulses. Ports: clk_i, rst_i, flush_req_i/ack_o,
// flush_o, stage_rst_o, stage_en_o, ready_o. All outputs registered.
module frontend_rst_ctrl
    import frontend_ctrl_pkg::*;
#(
    parameter int N_STAGES     = DEF_N_STAGES,
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int STAGE_GAP    = DEF_STAGE_GAP,
    parameter int N_REQ        = DEF_N_REQ,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_REQ-1:0]    flush_req_i,
    output logic [N_REQ-1:0]    flush_ack_o,
    output logic                flush_o,
    output logic [N_STAGES-1:0] stage_rst_o,
    output logic [N_STAGES-1:0] stage_en_o,
    output logic                ready_o
);

    localparam int CW = cnt_width(RST_CYCLES, STAGE_GAP, FLUSH_CYCLES);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] FL_LAST  = CW'(FLUSH_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [N_STAGES-1:0] stage_rst_q, stage_rst_d;
    logic [N_STAGES-1:0] stage_en_q, stage_en_d;
    logic                ready_q, ready_d;
    logic                flush_q, flush_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [N_REQ-1:0]    gnt;

    prio_arb #(
        .N(N_REQ)
    ) u_arb (
        .req(flush_req_i),
        .gnt(gnt)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stage_rst_d = stage_rst_q;
        stage_en_d  = stage_en_q;
        ready_d     = ready_q;
        flush_d     = flush_q;
        ack_d       = '0;

        unique case (state_q)
            HOLD: begin
                stage_rst_d = '1;
                stage_en_d  = '0;
                ready_d     = 1'b0;
                flush_d     = 1'b0;
                if (cnt_q == RST_LAST) begin
                    // Stage 0 leaves reset on the last hold edge.
                    cnt_d       = '0;
                    stage_rst_d = {N_STAGES{1'b1}} << 1;
                    state_d     = RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                // Stage reset is a shift register of ones draining
                // toward the top; enables trail it by one edge.
                stage_en_d = ~stage_rst_q;
                if (stage_rst_q == '0) begin
                    state_d    = RUN;
                    stage_en_d = '1;
                    ready_d    = 1'b1;
                    cnt_d      = '0;
                end else if (cnt_q == GAP_LAST) begin
                    stage_rst_d = stage_rst_q << 1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (|flush_req_i) begin
                    state_d    = FLUSH;
                    flush_d    = 1'b1;
                    ack_d      = gnt;
                    stage_en_d = '0;
                    ready_d    = 1'b0;
                    cnt_d      = '0;
                end
            end
            FLUSH: begin
                if (cnt_q == FL_LAST) begin
                    state_d    = RUN;
                    flush_d    = 1'b0;
                    stage_en_d = '1;
                    ready_d    = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            stage_rst_q <= '1;
            stage_en_q  <= '0;
            ready_q     <= 1'b0;
            flush_q     <= 1'b0;
            ack_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stage_rst_q <= stage_rst_d;
            stage_en_q  <= stage_en_d;
            ready_q     <= ready_d;
            flush_q     <= flush_d;
            ack_q       <= ack_d;
        end
    end

    assign flush_ack_o = ack_q;
    assign flush_o     = flush_q;
    assign stage_rst_o = stage_rst_q;
    assign stage_en_o  = stage_en_q;
    assign ready_o     = ready_q;

endmodule

// File: tb/tb_frontend_rst_ctrl.sv
// Self-checking bench for frontend_rst_ctrl with default parameters.
// Table-driven release/flush vectors plus directed corner sequences.
module tb_frontend_rst_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [1:0] flush_req_i = 2'b00;
    logic [1:0] flush_ack_o;
    logic       flush_o;
    logic [2:0] stage_rst_o;
    logic [2:0] stage_en_o;
    logic       ready_o;

    always #5 clk_i = ~clk_i;

    frontend_rst_ctrl dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .flush_req_i(flush_req_i),
        .flush_ack_o(flush_ack_o),
        .flush_o(flush_o),
        .stage_rst_o(stage_rst_o),
        .stage_en_o(stage_en_o),
        .ready_o(ready_o)
    );

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [2:0] srst;
        logic [2:0] en;
        logic       rdy;
        logic       fl;
        logic [1:0] ack;
    } vec_t;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    // Expected outputs at edge Ei of an undisturbed release sequence.
    function automatic vec_t base(input int i);
        vec_t v;
        v.rst  = 1'b0;
        v.req  = 2'b00;
        v.srst = (i < 3) ? 3'b111 : (i < 5) ? 3'b110 :
                 (i < 7) ? 3'b100 : 3'b000;
        v.en   = (i < 4) ? 3'b000 : (i < 6) ? 3'b001 :
                 (i < 8) ? 3'b011 : 3'b111;
        v.rdy  = (i >= 8);
        v.fl   = 1'b0;
        v.ack  = 2'b00;
        return v;
    endfunction

    // Expected outputs while a flush pulse is active after release.
    function automatic vec_t fl_vec(input int i, input logic [1:0] req,
                                    input logic [1:0] ack);
        vec_t v;
        v      = base(i);
        v.req  = req;
        v.fl   = 1'b1;
        v.rdy  = 1'b0;
        v.en   = 3'b000;
        v.ack  = ack;
        return v;
    endfunction

    function automatic vec_t rst_vec();
        vec_t v;
        v.rst  = 1'b1;
        v.req  = 2'b00;
        v.srst = 3'b111;
        v.en   = 3'b000;
        v.rdy  = 1'b0;
        v.fl   = 1'b0;
        v.ack  = 2'b00;
        return v;
    endfunction

    task automatic apply(input string name, input vec_t v);
        rst_i       = v.rst;
        flush_req_i = v.req;
        @(posedge clk_i);
        #1;
        checks++;
        if ({stage_rst_o, stage_en_o, ready_o, flush_o, flush_ack_o} !==
            {v.srst, v.en, v.rdy, v.fl, v.ack}) begin
            errors++;
            $display("FAIL %s: got rst=%b en=%b rdy=%b fl=%b ack=%b want rst=%b en=%b rdy=%b fl=%b ack=%b",
                     name, stage_rst_o, stage_en_o, ready_o, flush_o,
                     flush_ack_o, v.srst, v.en, v.rdy, v.fl, v.ack);
        end
    endtask

    task automatic do_reset(input string tag);
        apply({tag, "_rst0"}, rst_vec());
        armed = 1'b1;
        apply({tag, "_rst1"}, rst_vec());
    endtask

    task automatic run_base(input string tag, input int from, input int upto);
        for (int i = from; i <= upto; i++)
            apply($sformatf("%s_e%0d", tag, i), base(i));
    endtask

    always @(negedge clk_i) begin
        if (armed) begin
            checks++;
            if (!$onehot0(flush_ack_o) || (flush_o && ready_o) ||
                (ready_o && (stage_rst_o != 3'b000 || stage_en_o != 3'b111))) begin
                errors++;
                $display("FAIL invariant: got rst=%b en=%b rdy=%b fl=%b ack=%b",
                         stage_rst_o, stage_en_o, ready_o, flush_o, flush_ack_o);
            end
        end
    end

    vec_t tbl[23];
    vec_t v;

    initial begin
        for (int i = 0; i < 23; i++) tbl[i] = base(i);
        tbl[20] = fl_vec(20, 2'b10, 2'b10);
        tbl[21] = fl_vec(21, 2'b00, 2'b00);

        // Release sequence followed by a single flush from requester 1.
        do_reset("s1");
        for (int i = 0; i < 23; i++)
            apply($sformatf("s12_e%0d", i), tbl[i]);

        // Simultaneous requests: 0 wins, 1 waits for the next RUN edge.
        do_reset("s3");
        run_base("s3", 0, 19);
        apply("s3_e20", fl_vec(20, 2'b11, 2'b01));
        apply("s3_e21", fl_vec(21, 2'b10, 2'b00));
        v = base(22);
        v.req = 2'b10;
        apply("s3_e22", v);
        apply("s3_e23", fl_vec(23, 2'b10, 2'b10));
        apply("s3_e24", fl_vec(24, 2'b00, 2'b00));
        run_base("s3", 25, 26);

        // Request held through release is served on the first RUN edge.
        do_reset("s4");
        for (int i = 0; i <= 8; i++) begin
            v = base(i);
            v.req = 2'b01;
            apply($sformatf("s4_e%0d", i), v);
        end
        apply("s4_e9", fl_vec(9, 2'b01, 2'b01));
        apply("s4_e10", fl_vec(10, 2'b00, 2'b00));
        run_base("s4", 11, 12);

        // Reset in the middle of a flush pulse.
        do_reset("s5");
        run_base("s5", 0, 19);
        apply("s5_e20", fl_vec(20, 2'b01, 2'b01));
        apply("s5_e21", rst_vec());
        run_base("s5r", 0, 9);

        // Reset pulse during hold restarts the count.
        do_reset("s6");
        run_base("s6", 0, 1);
        apply("s6_e2", rst_vec());
        run_base("s6r", 0, 9);

        armed = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
